// File: rtl/vend_scheduler.sv
// Vending machine scheduler: coin credit, item selection,
// dispense handshake and quarter-by-quarter change return.
`timescale 1ns/1ps
module vend_scheduler #(
  parameter int unsigned PRICE0     = 3,
  parameter int unsigned PRICE1     = 4,
  parameter int unsigned PRICE2     = 5,
  parameter int unsigned PRICE3     = 8,
  parameter int unsigned CREDIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Q_in,
  input  logic       D_in,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  input  logic       cancel,
  output logic       disp_req,
  output logic [1:0] disp_id,
  input  logic       disp_ack,
  output logic       chg_req,
  input  logic       chg_ack,
  output logic [4:0] credit,
  output logic       coin_reject,
  output logic       sel_reject,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    CHANGE
  } state_t;

  localparam logic [5:0] MAX6 = 6'(CREDIT_MAX);

  state_t     state_q;
  state_t     state_d;
  logic [4:0] credit_q;
  logic [4:0] credit_d;
  logic [1:0] id_q;
  logic [1:0] id_d;
  logic       crej_q;
  logic       crej_d;
  logic       srej_q;
  logic       srej_d;

  logic [2:0] coin_val;
  logic       coin_any;
  logic [5:0] coin_sum;
  logic       coin_fits;
  logic [4:0] price;
  logic       afford;
  logic       has_credit;

  // Coin value (quarter=1, dollar=4) and the widened sum so
  // the ceiling compare can never be fooled by a 5-bit wrap.
  always_comb begin
    coin_val  = {D_in, 1'b0, Q_in};
    coin_any  = Q_in | D_in;
    coin_sum  = {1'b0, credit_q} + {3'b000, coin_val};
    coin_fits = (coin_sum <= MAX6);
  end

  // Price lookup for the requested item.
  always_comb begin
    price = 5'(PRICE0);
    unique case (sel_id)
      2'd0: price = 5'(PRICE0);
      2'd1: price = 5'(PRICE1);
      2'd2: price = 5'(PRICE2);
      2'd3: price = 5'(PRICE3);
      default: price = 5'(PRICE0);
    endcase
  end

  // Affordability and nonzero-credit flags.
  always_comb begin
    afford     = (credit_q >= price);
    has_credit = (credit_q != 5'd0);
  end

  // Next-state, credit, latched item and reject pulses.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    id_d     = id_q;
    crej_d   = 1'b0;
    srej_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cancel) begin
          crej_d = coin_any;
          if (has_credit) begin
            state_d = CHANGE;
          end
        end else if (sel_valid) begin
          crej_d = coin_any;
          if (afford) begin
            id_d     = sel_id;
            credit_d = credit_q - price;
            state_d  = DISPENSE;
          end else begin
            srej_d = 1'b1;
          end
        end else if (coin_any) begin
          if (coin_fits) begin
            credit_d = coin_sum[4:0];
          end else begin
            crej_d = 1'b1;
          end
        end
      end
      DISPENSE: begin
        crej_d = coin_any;
        if (disp_ack) begin
          state_d = has_credit ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        crej_d = coin_any;
        if (!has_credit) begin
          state_d = IDLE;
        end else if (chg_ack) begin
          credit_d = credit_q - 5'd1;
          if (credit_q == 5'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset forfeits any credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= 5'd0;
      id_q     <= 2'd0;
      crej_q   <= 1'b0;
      srej_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      id_q     <= id_d;
      crej_q   <= crej_d;
      srej_q   <= srej_d;
    end
  end

  // Handshake requests follow the registered state directly.
  always_comb begin
    disp_req    = (state_q == DISPENSE);
    chg_req     = (state_q == CHANGE);
    busy        = (state_q != IDLE);
    disp_id     = id_q;
    credit      = credit_q;
    coin_reject = crej_q;
    sel_reject  = srej_q;
  end

endmodule

// File: tb/tb_vend_scheduler.sv
// Testbench for vend_scheduler: directed vector table, async
// reset sequences and random traffic against a reference model.
`timescale 1ns/1ps
module tb_vend_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Q_in = 1'b0;
  logic       D_in = 1'b0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = 2'd0;
  logic       cancel = 1'b0;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       disp_ack = 1'b0;
  logic       chg_req;
  logic       chg_ack = 1'b0;
  logic [4:0] credit;
  logic       coin_reject;
  logic       sel_reject;
  logic       busy;

  int checks = 0;
  int errors = 0;

  vend_scheduler dut (
    .clk(clk), .rst(rst),
    .Q_in(Q_in), .D_in(D_in),
    .sel_valid(sel_valid), .sel_id(sel_id),
    .cancel(cancel),
    .disp_req(disp_req), .disp_id(disp_id),
    .disp_ack(disp_ack),
    .chg_req(chg_req), .chg_ack(chg_ack),
    .credit(credit), .coin_reject(coin_reject),
    .sel_reject(sel_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       q, d, sv;
    bit [1:0] sid;
    bit       can, da, ca;
    bit [4:0] cr;
    bit       dr;
    bit [1:0] di;
    bit       cq, cj, sj, bz;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    bit q, bit d, bit sv, bit [1:0] sid,
    bit can, bit da, bit ca,
    bit [4:0] cr, bit dr, bit [1:0] di,
    bit cq, bit cj, bit sj, bit bz);
    vec_t v;
    v.q = q; v.d = d; v.sv = sv; v.sid = sid;
    v.can = can; v.da = da; v.ca = ca;
    v.cr = cr; v.dr = dr; v.di = di;
    v.cq = cq; v.cj = cj; v.sj = sj; v.bz = bz;
    tbl.push_back(v);
  endfunction

  function automatic logic [11:0] got();
    return {credit, disp_req, disp_id, chg_req,
            coin_reject, sel_reject, busy};
  endfunction

  task automatic chk(input string nm,
                     input logic [11:0] exp);
    logic [11:0] g;
    g = got();
    checks++;
    if (g !== exp) begin
      errors++;
      $display("FAIL %s got cr=%0d dr=%b id=%0d cq=%b cj=%b sj=%b bz=%b want cr=%0d dr=%b id=%0d cq=%b cj=%b sj=%b bz=%b",
        nm, g[11:7], g[6], g[5:4], g[3], g[2], g[1], g[0],
        exp[11:7], exp[6], exp[5:4], exp[3], exp[2],
        exp[1], exp[0]);
    end
  endtask

  task automatic step(input bit q, input bit d,
                      input bit sv, input bit [1:0] sid,
                      input bit can, input bit da,
                      input bit ca);
    Q_in = q; D_in = d; sel_valid = sv; sel_id = sid;
    cancel = can; disp_ack = da; chg_ack = ca;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    Q_in = 0; D_in = 0; sel_valid = 0; sel_id = 0;
    cancel = 0; disp_ack = 0; chg_ack = 0;
  endtask

  task automatic do_reset();
    idle_in();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Reference model: customer-level view of the machine.
  int m_mode;   // 0 idle, 1 dispensing, 2 returning change
  int m_credit;
  int m_id;
  bit m_cj, m_sj;
  int price_of[4] = '{3, 4, 5, 8};

  task automatic model_reset();
    m_mode = 0; m_credit = 0; m_id = 0;
    m_cj = 0; m_sj = 0;
  endtask

  task automatic model_step(input bit q, input bit d,
                            input bit sv, input int sid,
                            input bit can, input bit da,
                            input bit ca);
    int val;
    val = (q ? 1 : 0) + (d ? 4 : 0);
    m_cj = 0;
    m_sj = 0;
    if (m_mode == 0) begin
      if (can) begin
        m_cj = (val > 0);
        if (m_credit > 0) m_mode = 2;
      end else if (sv) begin
        m_cj = (val > 0);
        if (m_credit >= price_of[sid]) begin
          m_credit -= price_of[sid];
          m_id = sid;
          m_mode = 1;
        end else begin
          m_sj = 1;
        end
      end else if (val > 0) begin
        if (m_credit + val > 16) m_cj = 1;
        else m_credit += val;
      end
    end else begin
      m_cj = (val > 0);
      if (m_mode == 1 && da)
        m_mode = (m_credit > 0) ? 2 : 0;
      else if (m_mode == 2 && ca) begin
        m_credit -= 1;
        if (m_credit == 0) m_mode = 0;
      end
    end
  endtask

  function automatic logic [11:0] model_exp();
    return {5'(m_credit), (m_mode == 1), 2'(m_id),
            (m_mode == 2), m_cj, m_sj, (m_mode != 0)};
  endfunction

  initial begin
    // q d sv sid can da ca | cr dr di cq cj sj bz
    add(0,1,0,0,0,0,0,  4,0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,  5,0,0,0,0,0,0);
    add(0,0,0,0,0,1,0,  5,0,0,0,0,0,0);
    add(0,0,1,1,0,0,0,  1,1,1,0,0,0,1);
    add(1,0,1,3,0,0,0,  1,1,1,0,1,0,1);
    add(0,0,0,0,0,0,0,  1,1,1,0,0,0,1);
    add(0,0,0,0,0,0,1,  1,1,1,0,0,0,1);
    add(0,0,0,0,0,1,0,  1,0,1,1,0,0,1);
    add(0,0,0,0,0,0,1,  0,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0,  1,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0,  2,0,1,0,0,0,0);
    add(0,0,1,0,0,0,0,  2,0,1,0,0,1,0);
    add(0,0,0,0,0,0,0,  2,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0,  3,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0,  4,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0,  5,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0,  6,0,1,0,0,0,0);
    add(1,0,1,0,1,0,0,  6,0,1,1,1,0,1);
    add(0,0,0,0,0,1,0,  6,0,1,1,0,0,1);
    add(0,1,0,0,0,0,0,  6,0,1,1,1,0,1);
    for (int k = 5; k >= 1; k--)
      add(0,0,0,0,0,0,1, 5'(k),0,1,1,0,0,1);
    add(0,0,0,0,0,0,1,  0,0,1,0,0,0,0);
    add(0,0,0,0,1,0,0,  0,0,1,0,0,0,0);
    add(0,1,0,0,0,0,0,  4,0,1,0,0,0,0);
    add(0,1,0,0,0,0,0,  8,0,1,0,0,0,0);
    add(0,1,0,0,0,0,0, 12,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0, 13,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0, 14,0,1,0,0,0,0);
    add(1,1,0,0,0,0,0, 14,0,1,0,1,0,0);
    add(0,1,0,0,0,0,0, 14,0,1,0,1,0,0);
    add(1,0,0,0,0,0,0, 15,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0, 16,0,1,0,0,0,0);
    add(1,0,0,0,0,0,0, 16,0,1,0,1,0,0);
    add(0,0,1,3,0,0,0,  8,1,3,0,0,0,1);
    add(0,0,0,0,0,1,0,  8,0,3,1,0,0,1);

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    #1 chk("reset_state", 12'h000);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vector table
    foreach (tbl[i]) begin
      step(tbl[i].q, tbl[i].d, tbl[i].sv, tbl[i].sid,
           tbl[i].can, tbl[i].da, tbl[i].ca);
      chk($sformatf("vec%0d", i),
          {tbl[i].cr, tbl[i].dr, tbl[i].di, tbl[i].cq,
           tbl[i].cj, tbl[i].sj, tbl[i].bz});
    end

    // Async reset mid-dispense, late ack ignored
    do_reset();
    step(0,1,0,0,0,0,0);
    step(1,0,0,0,0,0,0);
    step(0,0,1,1,0,0,0);
    chk("pre_rst_disp", {5'd1, 1'b1, 2'd1, 4'b0001});
    idle_in();
    #2 rst = 1'b1;
    #1 chk("async_rst", 12'h000);
    @(posedge clk);
    #1 rst = 1'b0;
    step(0,0,0,0,0,1,0);
    chk("late_disp_ack", 12'h000);
    step(0,0,0,0,0,0,1);
    chk("late_chg_ack", 12'h000);

    // Async reset mid-change, first coin right after release
    step(0,1,0,0,0,0,0);
    step(0,0,0,0,1,0,0);
    chk("pre_rst_chg", {5'd4, 1'b0, 2'd0, 4'b1001});
    idle_in();
    #2 rst = 1'b1;
    #1 chk("async_rst_chg", 12'h000);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1,0,0,0,0,0,1);
    chk("first_coin", {5'd1, 7'b0});

    // Random traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit q, d, sv, can, da, ca;
      bit [1:0] sid;
      q   = ($urandom % 3) == 0;
      d   = ($urandom % 5) == 0;
      sv  = ($urandom % 5) == 0;
      sid = 2'($urandom);
      can = ($urandom % 14) == 0;
      da  = ($urandom % 3) == 0;
      ca  = ($urandom % 2) == 0;
      step(q, d, sv, sid, can, da, ca);
      model_step(q, d, sv, int'(sid), can, da, ca);
      chk($sformatf("rand%0d", n), model_exp());
    end

    idle_in();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
